// File: rtl/vsd_caravel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vsd_caravel_pkg
//  Description : Shared constants, reset values, SPI commands and FSM states
//                for the reduced Caravel housekeeping chip-top.
//  Revision    : 1.0 - initial release
// ============================================================================
package vsd_caravel_pkg;

    localparam logic [7:0] c_addr_status      = 8'h00;
    localparam logic [7:0] c_addr_mfg_hi      = 8'h01;
    localparam logic [7:0] c_addr_mfg_lo      = 8'h02;
    localparam logic [7:0] c_addr_prod_id     = 8'h03;
    localparam logic [7:0] c_addr_mask_rev    = 8'h04;
    localparam logic [7:0] c_addr_pll_ena     = 8'h08;
    localparam logic [7:0] c_addr_pll_bypass  = 8'h09;
    localparam logic [7:0] c_addr_irq         = 8'h0A;
    localparam logic [7:0] c_addr_ext_reset   = 8'h0B;
    localparam logic [7:0] c_addr_trap        = 8'h0C;
    localparam logic [7:0] c_addr_pll_trim0   = 8'h0D;
    localparam logic [7:0] c_addr_pll_trim1   = 8'h0E;
    localparam logic [7:0] c_addr_pll_trim2   = 8'h0F;
    localparam logic [7:0] c_addr_pll_trim3   = 8'h10;
    localparam logic [7:0] c_addr_pll_source  = 8'h11;
    localparam logic [7:0] c_addr_pll_div     = 8'h12;

    localparam logic [1:0]  c_rst_pll_ena     = 2'b10;
    localparam logic        c_rst_pll_bypass  = 1'b1;
    localparam logic        c_rst_irq         = 1'b0;
    localparam logic        c_rst_ext_reset   = 1'b0;
    localparam logic [25:0] c_rst_pll_trim    = 26'h3FFEFFF;
    localparam logic [5:0]  c_rst_pll_source  = 6'h12;
    localparam logic [4:0]  c_rst_pll_div     = 5'h04;

    localparam logic [7:0] c_cmd_write = 8'h80;
    localparam logic [7:0] c_cmd_read  = 8'h40;
    localparam logic [7:0] c_cmd_rdwr  = 8'hC0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_ADDR = 2'd2,
        ST_DATA = 2'd3
    } hk_state_t;

endpackage
`default_nettype wire

// File: rtl/vsd_caravel_if.sv
`default_nettype none
// ============================================================================
//  Module      : vsd_caravel_if
//  Description : Byte-wide register access bus between the housekeeping SPI
//                slave (master side) and the register bank (slave side).
//  Revision    : 1.0 - initial release
// ============================================================================
interface vsd_caravel_if;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       we;
    logic [7:0] rdata;
    logic       rd_load;

    modport master (output addr, output wdata, output we, output rd_load, input rdata);
    modport slave  (input addr, input wdata, input we, input rd_load, output rdata);
endinterface
`default_nettype wire

// File: rtl/vsd_hkspi_slave.sv
`default_nettype none
// ============================================================================
//  Module      : vsd_hkspi_slave
//  Description : Housekeeping SPI slave, fully in the system clock domain:
//                pin synchronisers, SCK edge detect, framing FSM and shifters.
//  Revision    : 1.0 - initial release
// ============================================================================
module vsd_hkspi_slave
    import vsd_caravel_pkg::*;
(
    input  wire           clk,
    input  wire           rst_n,
    input  wire           i_sck,
    input  wire           i_csb,
    input  wire           i_sdi,
    output logic          o_sdo,
    vsd_caravel_if.master bus
);

    logic       r_sck_meta, r_sck_sync, r_sck_prev;
    logic       r_csb_meta, r_csb_sync;
    logic       r_sdi_meta, r_sdi_sync;

    hk_state_t  r_state, w_state_next;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_shift_in;
    logic [7:0] r_cmd;
    logic [7:0] r_addr;
    logic [7:0] r_tx;
    logic       r_load_pend;

    logic       w_sck_rise;
    logic [7:0] w_byte;
    logic       w_byte_done;
    logic       w_is_write;
    logic       w_is_read;
    logic       w_we;

    always_comb begin
        w_sck_rise   = r_sck_sync & ~r_sck_prev;
        w_byte       = {r_shift_in, r_sdi_sync};
        w_byte_done  = w_sck_rise && (r_bit_cnt == 3'd7);
        w_is_write   = (r_cmd == c_cmd_write) || (r_cmd == c_cmd_rdwr);
        w_is_read    = (r_cmd == c_cmd_read)  || (r_cmd == c_cmd_rdwr);
        w_state_next = r_state;
        w_we         = 1'b0;
        if (r_csb_sync) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_next = ST_CMD;
                ST_CMD:  if (w_byte_done) w_state_next = ST_ADDR;
                ST_ADDR: if (w_byte_done) w_state_next = ST_DATA;
                ST_DATA: begin
                    w_state_next = ST_DATA;
                    w_we         = w_byte_done && w_is_write;
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_meta  <= 1'b0;
            r_sck_sync  <= 1'b0;
            r_sck_prev  <= 1'b0;
            r_csb_meta  <= 1'b1;
            r_csb_sync  <= 1'b1;
            r_sdi_meta  <= 1'b0;
            r_sdi_sync  <= 1'b0;
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift_in  <= 7'd0;
            r_cmd       <= 8'h00;
            r_addr      <= 8'h00;
            r_tx        <= 8'h00;
            r_load_pend <= 1'b0;
        end else begin
            r_sck_meta  <= i_sck;
            r_sck_sync  <= r_sck_meta;
            r_sck_prev  <= r_sck_sync;
            r_csb_meta  <= i_csb;
            r_csb_sync  <= r_csb_meta;
            r_sdi_meta  <= i_sdi;
            r_sdi_sync  <= r_sdi_meta;
            r_state     <= w_state_next;
            r_load_pend <= 1'b0;
            // A deselected or idle slave drops any partial byte and silences SDO.
            if (r_csb_sync || (r_state == ST_IDLE)) begin
                r_bit_cnt  <= 3'd0;
                r_shift_in <= 7'd0;
                r_tx       <= 8'h00;
            end else begin
                if (r_load_pend) begin
                    r_tx <= bus.rdata;
                end
                if (w_sck_rise) begin
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                    r_shift_in <= w_byte[6:0];
                    case (r_state)
                        ST_CMD: if (w_byte_done) r_cmd <= w_byte;
                        ST_ADDR: if (w_byte_done) begin
                            r_addr      <= w_byte;
                            r_load_pend <= w_is_read;
                        end
                        ST_DATA: if (w_byte_done) begin
                            r_addr      <= r_addr + 8'd1;
                            r_load_pend <= w_is_read;
                        end else begin
                            r_tx <= {r_tx[6:0], 1'b0};
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // The bank is read one cycle after the address settles, so rdata matches r_addr.
    assign bus.addr    = r_addr;
    assign bus.wdata   = w_byte;
    assign bus.we      = w_we;
    assign bus.rd_load = r_load_pend;
    assign o_sdo       = r_tx[7];

endmodule
`default_nettype wire

// File: rtl/vsd_caravel.sv
`default_nettype none
// ============================================================================
//  Module      : vsd_caravel
//  Description : Reduced Caravel chip-top: housekeeping SPI on user I/O pins
//                backed by the housekeeping register bank; flash/UART idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module vsd_caravel
    import vsd_caravel_pkg::*;
#(
    parameter logic [11:0] MFG_ID   = 12'h456,
    parameter logic [7:0]  PROD_ID  = 8'h11,
    parameter logic [7:0]  MASK_REV = 8'h00
) (
    input  wire        vddio,
    input  wire        vddio_2,
    input  wire        vssio,
    input  wire        vssio_2,
    input  wire        vdda,
    input  wire        vssa,
    input  wire        vccd,
    input  wire        vssd,
    input  wire        vdda1,
    input  wire        vdda1_2,
    input  wire        vdda2,
    input  wire        vssa1,
    input  wire        vssa1_2,
    input  wire        vssa2,
    input  wire        vccd1,
    input  wire        vccd2,
    input  wire        vssd1,
    input  wire        vssd2,
    input  wire        clock,
    input  wire        resetb,
    inout  wire        gpio,
    inout  wire [37:0] mprj_io,
    output wire        flash_csb,
    output wire        flash_clk,
    inout  wire        flash_io0,
    inout  wire        flash_io1
);

    vsd_caravel_if bus_if ();

    logic        w_sdo;
    logic [7:0]  w_rdata;
    logic        w_core_reset;
    logic        w_unused;

    logic [1:0]  r_pll_ena;
    logic        r_pll_bypass;
    logic        r_irq;
    logic        r_ext_reset;
    logic [25:0] r_pll_trim;
    logic [5:0]  r_pll_source;
    logic [4:0]  r_pll_div;

    vsd_hkspi_slave u_hkspi (
        .clk   (clock),
        .rst_n (resetb),
        .i_sck (mprj_io[4]),
        .i_csb (mprj_io[3]),
        .i_sdi (mprj_io[2]),
        .o_sdo (w_sdo),
        .bus   (bus_if.master)
    );

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_pll_ena    <= c_rst_pll_ena;
            r_pll_bypass <= c_rst_pll_bypass;
            r_irq        <= c_rst_irq;
            r_ext_reset  <= c_rst_ext_reset;
            r_pll_trim   <= c_rst_pll_trim;
            r_pll_source <= c_rst_pll_source;
            r_pll_div    <= c_rst_pll_div;
        end else if (bus_if.we) begin
            case (bus_if.addr)
                c_addr_pll_ena:    r_pll_ena          <= bus_if.wdata[1:0];
                c_addr_pll_bypass: r_pll_bypass       <= bus_if.wdata[0];
                c_addr_irq:        r_irq              <= bus_if.wdata[0];
                c_addr_ext_reset:  r_ext_reset        <= bus_if.wdata[0];
                c_addr_pll_trim0:  r_pll_trim[7:0]    <= bus_if.wdata;
                c_addr_pll_trim1:  r_pll_trim[15:8]   <= bus_if.wdata;
                c_addr_pll_trim2:  r_pll_trim[23:16]  <= bus_if.wdata;
                c_addr_pll_trim3:  r_pll_trim[25:24]  <= bus_if.wdata[1:0];
                c_addr_pll_source: r_pll_source       <= bus_if.wdata[5:0];
                c_addr_pll_div:    r_pll_div          <= bus_if.wdata[4:0];
                default: ;
            endcase
        end
    end

    // Status, trap and unmapped addresses all read as zero.
    always_comb begin
        w_rdata = 8'h00;
        case (bus_if.addr)
            c_addr_mfg_hi:     w_rdata = {4'h0, MFG_ID[11:8]};
            c_addr_mfg_lo:     w_rdata = MFG_ID[7:0];
            c_addr_prod_id:    w_rdata = PROD_ID;
            c_addr_mask_rev:   w_rdata = MASK_REV;
            c_addr_pll_ena:    w_rdata = {6'h00, r_pll_ena};
            c_addr_pll_bypass: w_rdata = {7'h00, r_pll_bypass};
            c_addr_irq:        w_rdata = {7'h00, r_irq};
            c_addr_ext_reset:  w_rdata = {7'h00, r_ext_reset};
            c_addr_pll_trim0:  w_rdata = r_pll_trim[7:0];
            c_addr_pll_trim1:  w_rdata = r_pll_trim[15:8];
            c_addr_pll_trim2:  w_rdata = r_pll_trim[23:16];
            c_addr_pll_trim3:  w_rdata = {6'h00, r_pll_trim[25:24]};
            c_addr_pll_source: w_rdata = {2'h0, r_pll_source};
            c_addr_pll_div:    w_rdata = {3'h0, r_pll_div};
            default:           w_rdata = 8'h00;
        endcase
    end

    assign bus_if.rdata = w_rdata;

    // Core reset leaves the register bank and SPI untouched by design.
    assign w_core_reset = r_ext_reset;

    generate
        for (genvar i = 0; i < 38; i++) begin : g_mprj_pin
            if (i == 1) begin : g_sdo
                assign mprj_io[i] = w_sdo;
            end else if (i == 6) begin : g_uart_tx
                assign mprj_io[i] = 1'b1;
            end else begin : g_hiz
                assign mprj_io[i] = 1'bz;
            end
        end
    endgenerate

    assign gpio      = 1'bz;
    assign flash_io0 = 1'bz;
    assign flash_io1 = 1'bz;
    assign flash_csb = 1'b1;
    assign flash_clk = 1'b0;

    assign w_unused = ^{vddio, vddio_2, vssio, vssio_2, vdda, vssa, vccd, vssd,
                        vdda1, vdda1_2, vdda2, vssa1, vssa1_2, vssa2, vccd1,
                        vccd2, vssd1, vssd2, gpio, flash_io0, flash_io1,
                        mprj_io, bus_if.rd_load, w_core_reset};

endmodule
`default_nettype wire

// File: tb/tb_vsd_caravel.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vsd_caravel
//  Description : Directed self-checking bench for the Caravel housekeeping SPI
//                chip-top, driving the SPI master from the pins.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vsd_caravel;

    localparam int H = 6;

    logic clock  = 1'b0;
    logic resetb = 1'b0;
    logic sck    = 1'b0;
    logic csb    = 1'b1;
    logic sdi    = 1'b0;
    logic vpwr   = 1'b1;
    logic vgnd   = 1'b0;

    wire [37:0] mprj_io;
    wire        gpio, flash_io0, flash_io1, flash_csb, flash_clk;

    assign mprj_io[4] = sck;
    assign mprj_io[3] = csb;
    assign mprj_io[2] = sdi;

    vsd_caravel dut (
        .vddio(vpwr), .vddio_2(vpwr), .vssio(vgnd), .vssio_2(vgnd),
        .vdda(vpwr), .vssa(vgnd), .vccd(vpwr), .vssd(vgnd),
        .vdda1(vpwr), .vdda1_2(vpwr), .vdda2(vpwr), .vssa1(vgnd),
        .vssa1_2(vgnd), .vssa2(vgnd), .vccd1(vpwr), .vccd2(vpwr),
        .vssd1(vgnd), .vssd2(vgnd),
        .clock(clock), .resetb(resetb), .gpio(gpio), .mprj_io(mprj_io),
        .flash_csb(flash_csb), .flash_clk(flash_clk),
        .flash_io0(flash_io0), .flash_io1(flash_io1)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] tx_buf [32];
    logic [7:0] rx_buf [32];

    typedef struct {
        logic       do_wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs [13];
    logic [7:0] exp_map [19];

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Mode 0, MSB first; SDO is sampled just before each rising SCK.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            sdi = tx[i];
            wait_clk(H);
            rx[i] = mprj_io[1];
            sck = 1'b1;
            wait_clk(H);
            sck = 1'b0;
        end
    endtask

    task automatic frame_start();
        csb = 1'b0;
        wait_clk(H);
    endtask

    task automatic frame_end();
        wait_clk(H);
        csb = 1'b1;
        sdi = 1'b0;
        wait_clk(2 * H);
    endtask

    task automatic spi_frame(input logic [7:0] cmd, input logic [7:0] addr, input int n);
        logic [7:0] dummy;
        frame_start();
        spi_bits(cmd, 8, dummy);
        spi_bits(addr, 8, dummy);
        for (int i = 0; i < n; i++) spi_bits(tx_buf[i], 8, rx_buf[i]);
        frame_end();
    endtask

    task automatic spi_write1(input logic [7:0] addr, input logic [7:0] data);
        tx_buf[0] = data;
        spi_frame(8'h80, addr, 1);
    endtask

    task automatic spi_read1(input logic [7:0] addr, output logic [7:0] data);
        tx_buf[0] = 8'h00;
        spi_frame(8'h40, addr, 1);
        data = rx_buf[0];
    endtask

    task automatic pulse_reset();
        resetb = 1'b0;
        wait_clk(3);
        resetb = 1'b1;
        wait_clk(3);
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] dummy;

        vecs[0]  = '{1'b0, 8'h03, 8'h00, 8'h11};
        vecs[1]  = '{1'b1, 8'h08, 8'hFF, 8'h03};
        vecs[2]  = '{1'b1, 8'h09, 8'hFE, 8'h00};
        vecs[3]  = '{1'b1, 8'h0A, 8'h03, 8'h01};
        vecs[4]  = '{1'b1, 8'h11, 8'hFF, 8'h3F};
        vecs[5]  = '{1'b1, 8'h12, 8'hE7, 8'h07};
        vecs[6]  = '{1'b1, 8'h10, 8'hFC, 8'h00};
        vecs[7]  = '{1'b1, 8'h03, 8'h99, 8'h11};
        vecs[8]  = '{1'b1, 8'h0C, 8'h55, 8'h00};
        vecs[9]  = '{1'b1, 8'h20, 8'h77, 8'h00};
        vecs[10] = '{1'b1, 8'h0F, 8'h5A, 8'h5A};
        vecs[11] = '{1'b0, 8'h02, 8'h00, 8'h56};
        vecs[12] = '{1'b1, 8'h00, 8'hAA, 8'h00};

        exp_map = '{8'h00, 8'h04, 8'h56, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00,
                    8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hEF, 8'hFF,
                    8'h03, 8'h12, 8'h04};

        wait_clk(4);
        check("sdo_in_reset", {31'd0, mprj_io[1]}, 32'd0);
        resetb = 1'b1;
        wait_clk(4);
        check("flash_csb_idle", {31'd0, flash_csb}, 32'd1);
        check("flash_clk_idle", {31'd0, flash_clk}, 32'd0);
        check("uart_tx_idle",   {31'd0, mprj_io[6]}, 32'd1);
        check("core_reset_init", {31'd0, dut.w_core_reset}, 32'd0);

        spi_read1(8'h03, rd);
        check("read_prod_id", {24'd0, rd}, 32'h11);

        spi_write1(8'h0B, 8'h01);
        check("core_reset_set", {31'd0, dut.w_core_reset}, 32'd1);
        spi_read1(8'h0B, rd);
        check("ext_reset_rd1", {24'd0, rd}, 32'h01);
        spi_write1(8'h0B, 8'h00);
        check("core_reset_clr", {31'd0, dut.w_core_reset}, 32'd0);
        spi_read1(8'h0B, rd);
        check("ext_reset_rd0", {24'd0, rd}, 32'h00);

        for (int i = 0; i < 19; i++) tx_buf[i] = 8'h00;
        spi_frame(8'h40, 8'h00, 19);
        for (int i = 0; i < 19; i++)
            check($sformatf("map_stream[%0d]", i), {24'd0, rx_buf[i]}, {24'd0, exp_map[i]});

        tx_buf[0] = 8'hAA;
        tx_buf[1] = 8'h55;
        spi_frame(8'h80, 8'h0D, 2);
        spi_frame(8'h40, 8'h0D, 2);
        check("trim0_written", {24'd0, rx_buf[0]}, 32'hAA);
        check("trim1_written", {24'd0, rx_buf[1]}, 32'h55);
        pulse_reset();
        spi_frame(8'h40, 8'h0D, 2);
        check("trim0_reset", {24'd0, rx_buf[0]}, 32'hFF);
        check("trim1_reset", {24'd0, rx_buf[1]}, 32'hEF);

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].do_wr) spi_write1(vecs[i].addr, vecs[i].wdata);
            spi_read1(vecs[i].addr, rd);
            check($sformatf("vec%0d_addr%02h", i, vecs[i].addr), {24'd0, rd}, {24'd0, vecs[i].exp});
        end

        pulse_reset();
        tx_buf[0] = 8'h01;
        tx_buf[1] = 8'h00;
        spi_frame(8'hC0, 8'h08, 2);
        check("rdwr_old_08", {24'd0, rx_buf[0]}, 32'h02);
        check("rdwr_old_09", {24'd0, rx_buf[1]}, 32'h01);
        spi_read1(8'h08, rd);
        check("rdwr_new_08", {24'd0, rd}, 32'h01);
        spi_read1(8'h09, rd);
        check("rdwr_new_09", {24'd0, rd}, 32'h00);

        tx_buf[0] = 8'h1F;
        spi_frame(8'h00, 8'h12, 1);
        check("noop_sdo", {24'd0, rx_buf[0]}, 32'h00);
        spi_read1(8'h12, rd);
        check("noop_no_write", {24'd0, rd}, 32'h04);

        for (int i = 0; i < 4; i++) tx_buf[i] = 8'h00;
        spi_frame(8'h40, 8'hFF, 2);
        check("wrap_ff", {24'd0, rx_buf[0]}, 32'h00);
        check("wrap_00", {24'd0, rx_buf[1]}, 32'h00);
        spi_frame(8'h40, 8'hFE, 4);
        check("wrap4_fe", {24'd0, rx_buf[0]}, 32'h00);
        check("wrap4_ff", {24'd0, rx_buf[1]}, 32'h00);
        check("wrap4_00", {24'd0, rx_buf[2]}, 32'h00);
        check("wrap4_01", {24'd0, rx_buf[3]}, 32'h04);

        pulse_reset();
        frame_start();
        spi_bits(8'h80, 8, dummy);
        spi_bits(8'h08, 8, dummy);
        spi_bits(8'h00, 4, dummy);
        frame_end();
        spi_read1(8'h08, rd);
        check("partial_no_write", {24'd0, rd}, 32'h02);

        frame_start();
        spi_bits(8'h40, 8, dummy);
        spi_bits(8'h03, 8, dummy);
        wait_clk(H);
        check("sdo_mid_read", {31'd0, mprj_io[1]}, 32'd0);
        csb = 1'b1;
        wait_clk(2 * H);
        check("sdo_csb_high", {31'd0, mprj_io[1]}, 32'd0);
        check("flash_csb_end", {31'd0, flash_csb}, 32'd1);
        check("flash_clk_end", {31'd0, flash_clk}, 32'd0);
        check("uart_tx_end",   {31'd0, mprj_io[6]}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
